// File: rtl/atc_de.sv
// ATC D->E pipeline register with tnew countdown during holds.
// Bubbles on DEclr, holds on !en, and never forwards to register 0.
module atc_de (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        DEclr,
    input  logic [4:0]  ra1D,
    input  logic [4:0]  ra2D,
    input  logic [4:0]  waD,
    input  logic [2:0]  resD,
    input  logic [1:0]  tnewD,
    input  logic [4:0]  excD,
    input  logic        bdD,
    input  logic [31:0] pcD,
    output logic [4:0]  ra1E,
    output logic [4:0]  ra2E,
    output logic [4:0]  waE,
    output logic [2:0]  resE,
    output logic [1:0]  tnewE,
    output logic [1:0]  tnewM,
    output logic [4:0]  excE,
    output logic        bdE,
    output logic [31:0] pcE,
    output logic        validE
);

    logic [1:0] tnew_dec;
    logic       wb_ok;

    // Saturating countdown shared by the hold path and the M-stage hand-off
    always_comb begin
        tnew_dec = 2'd0;
        if (tnewE != 2'd0)
            tnew_dec = tnewE - 2'd1;
    end

    assign tnewM = tnew_dec;

    // Only a non-excepting instruction with a real nonzero target writes back
    assign wb_ok = (excD == 5'd0) && (resD != 3'd0) && (waD != 5'd0);

    // Stage register: bubble beats hold beats load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra1E   <= 5'd0;
            ra2E   <= 5'd0;
            waE    <= 5'd0;
            resE   <= 3'd0;
            tnewE  <= 2'd0;
            excE   <= 5'd0;
            bdE    <= 1'b0;
            pcE    <= 32'd0;
            validE <= 1'b0;
        end else if (DEclr) begin
            ra1E   <= 5'd0;
            ra2E   <= 5'd0;
            waE    <= 5'd0;
            resE   <= 3'd0;
            tnewE  <= 2'd0;
            excE   <= 5'd0;
            bdE    <= 1'b0;
            pcE    <= pcD;
            validE <= 1'b0;
        end else if (!en) begin
            tnewE  <= tnew_dec;
        end else begin
            ra1E   <= ra1D;
            ra2E   <= ra2D;
            waE    <= wb_ok ? waD : 5'd0;
            resE   <= wb_ok ? resD : 3'd0;
            tnewE  <= tnewD;
            excE   <= excD;
            bdE    <= bdD;
            pcE    <= pcD;
            validE <= 1'b1;
        end
    end

endmodule

// File: tb/tb_atc_de.sv
// Directed bench for atc_de: load, hold countdown, bubble priority,
// writeback suppression and asynchronous reset.
module tb_atc_de;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        DEclr;
    logic [4:0]  ra1D, ra2D, waD, excD;
    logic [2:0]  resD;
    logic [1:0]  tnewD;
    logic        bdD;
    logic [31:0] pcD;
    logic [4:0]  ra1E, ra2E, waE, excE;
    logic [2:0]  resE;
    logic [1:0]  tnewE, tnewM;
    logic        bdE, validE;
    logic [31:0] pcE;

    int n_cmp = 0;
    int n_err = 0;

    // {ra1,ra2,wa,res,tnewE,tnewM,exc,bd,valid,pc}
    logic [60:0] e_bus;
    logic [60:0] exp_v;

    assign e_bus = {ra1E, ra2E, waE, resE, tnewE, tnewM,
                    excE, bdE, validE, pcE};

    always #5 clk = ~clk;

    atc_de dut (
        .clk(clk), .rst(rst), .en(en), .DEclr(DEclr),
        .ra1D(ra1D), .ra2D(ra2D), .waD(waD), .resD(resD),
        .tnewD(tnewD), .excD(excD), .bdD(bdD), .pcD(pcD),
        .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
        .tnewE(tnewE), .tnewM(tnewM), .excE(excE), .bdE(bdE),
        .pcE(pcE), .validE(validE)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] wa, input logic [2:0] rs,
                         input logic [1:0] tn, input logic [4:0] ex,
                         input logic bd, input logic [31:0] pc);
        ra1D = a1; ra2D = a2; waD = wa; resD = rs;
        tnewD = tn; excD = ex; bdD = bd; pcD = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; DEclr = 1'b0;
        set_d(5'd1, 5'd2, 5'd3, 3'd1, 2'd1, 5'd0, 1'b1, 32'h1234);
        #2;
        n_cmp++;
        exp_v = 61'd0;
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL reset got %h want %h", e_bus, exp_v);
        end
        tick();
        n_cmp++;
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL reset_edge got %h want %h", e_bus, exp_v);
        end
        rst = 1'b1;
    endtask

    task automatic test_load();
        en = 1'b1; DEclr = 1'b0;
        set_d(5'd3, 5'd4, 5'd5, 3'd2, 2'd2, 5'd0, 1'b0, 32'h3000);
        tick();
        n_cmp++;
        exp_v = {5'd3, 5'd4, 5'd5, 3'd2, 2'd2, 2'd1,
                 5'd0, 1'b0, 1'b1, 32'h3000};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL load got %h want %h", e_bus, exp_v);
        end
    endtask

    task automatic test_hold();
        logic [1:0] tn_exp [3];
        tn_exp[0] = 2'd1; tn_exp[1] = 2'd0; tn_exp[2] = 2'd0;
        en = 1'b0;
        set_d(5'd9, 5'd10, 5'd11, 3'd5, 2'd3, 5'd4, 1'b1, 32'h9999);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            exp_v = {5'd3, 5'd4, 5'd5, 3'd2, tn_exp[i], 2'd0,
                     5'd0, 1'b0, 1'b1, 32'h3000};
            if (e_bus !== exp_v) begin
                n_err++;
                $display("FAIL hold%0d got %h want %h", i, e_bus, exp_v);
            end
        end
    endtask

    task automatic test_bubble();
        DEclr = 1'b1; en = 1'b0;
        set_d(5'd9, 5'd10, 5'd11, 3'd5, 2'd3, 5'd4, 1'b1, 32'h3004);
        tick();
        n_cmp++;
        exp_v = {5'd0, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0,
                 5'd0, 1'b0, 1'b0, 32'h3004};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL bubble_hold got %h want %h", e_bus, exp_v);
        end
        en = 1'b1;
        pcD = 32'h4440;
        tick();
        n_cmp++;
        exp_v = {5'd0, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0,
                 5'd0, 1'b0, 1'b0, 32'h4440};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL bubble_en got %h want %h", e_bus, exp_v);
        end
        DEclr = 1'b0;
    endtask

    task automatic test_exception();
        en = 1'b1; DEclr = 1'b0;
        set_d(5'd1, 5'd2, 5'd8, 3'd1, 2'd1, 5'd10, 1'b1, 32'h3008);
        tick();
        n_cmp++;
        exp_v = {5'd1, 5'd2, 5'd0, 3'd0, 2'd1, 2'd0,
                 5'd10, 1'b1, 1'b1, 32'h3008};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL exc_squash got %h want %h", e_bus, exp_v);
        end
    endtask

    task automatic test_reg0();
        set_d(5'd6, 5'd7, 5'd0, 3'd3, 2'd3, 5'd0, 1'b0, 32'h300c);
        tick();
        n_cmp++;
        exp_v = {5'd6, 5'd7, 5'd0, 3'd0, 2'd3, 2'd2,
                 5'd0, 1'b0, 1'b1, 32'h300c};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL wa_zero got %h want %h", e_bus, exp_v);
        end
        set_d(5'd2, 5'd3, 5'd7, 3'd0, 2'd0, 5'd0, 1'b0, 32'h3010);
        tick();
        n_cmp++;
        exp_v = {5'd2, 5'd3, 5'd0, 3'd0, 2'd0, 2'd0,
                 5'd0, 1'b0, 1'b1, 32'h3010};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL res_zero got %h want %h", e_bus, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        set_d(5'd31, 5'd30, 5'd29, 3'd7, 2'd3, 5'd0, 1'b1, 32'hffff_fffc);
        tick();
        n_cmp++;
        exp_v = {5'd31, 5'd30, 5'd29, 3'd7, 2'd3, 2'd2,
                 5'd0, 1'b1, 1'b1, 32'hffff_fffc};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL b2b_0 got %h want %h", e_bus, exp_v);
        end
        set_d(5'd12, 5'd13, 5'd14, 3'd4, 2'd1, 5'd0, 1'b0, 32'h0000_0040);
        tick();
        n_cmp++;
        exp_v = {5'd12, 5'd13, 5'd14, 3'd4, 2'd1, 2'd0,
                 5'd0, 1'b0, 1'b1, 32'h0000_0040};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL b2b_1 got %h want %h", e_bus, exp_v);
        end
    endtask

    task automatic test_hold_from3();
        set_d(5'd5, 5'd6, 5'd9, 3'd2, 2'd3, 5'd0, 1'b0, 32'h5000);
        tick();
        en = 1'b0;
        tick();
        n_cmp++;
        exp_v = {5'd5, 5'd6, 5'd9, 3'd2, 2'd2, 2'd1,
                 5'd0, 1'b0, 1'b1, 32'h5000};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL hold3_a got %h want %h", e_bus, exp_v);
        end
        tick();
        n_cmp++;
        exp_v = {5'd5, 5'd6, 5'd9, 3'd2, 2'd1, 2'd0,
                 5'd0, 1'b0, 1'b1, 32'h5000};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL hold3_b got %h want %h", e_bus, exp_v);
        end
    endtask

    task automatic test_async_reset();
        // Stage is held and loaded here; reset lands mid-cycle
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        exp_v = 61'd0;
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL async_rst got %h want %h", e_bus, exp_v);
        end
        tick();
        rst = 1'b1;
        en = 1'b0;
        tick();
        n_cmp++;
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL rst_stays_empty got %h want %h", e_bus, exp_v);
        end
        en = 1'b1;
        set_d(5'd3, 5'd4, 5'd5, 3'd2, 2'd2, 5'd0, 1'b0, 32'h3000);
        tick();
        n_cmp++;
        exp_v = {5'd3, 5'd4, 5'd5, 3'd2, 2'd2, 2'd1,
                 5'd0, 1'b0, 1'b1, 32'h3000};
        if (e_bus !== exp_v) begin
            n_err++;
            $display("FAIL post_rst_load got %h want %h", e_bus, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load();
        test_hold();
        test_bubble();
        test_exception();
        test_reg0();
        test_back_to_back();
        test_hold_from3();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/atc_de.md
ATC_DE -- requirements
Module: atc_de

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`, reset `rst`, asynchronous, active-low.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- en  in  1  1 = stage may advance; 0 = hold, for MD-unit busy or global freeze
- DEclr  in  1  synchronous bubble insert (stall from D or exception flush)
- ra1D, ra2D  in  5  D-stage source register numbers
- waD  in  5  D-stage destination register number
- resD  in  3  D-stage result-source class; 0 = no writeback
- tnewD  in  2  cycles until the D-stage instruction's result is available from E
- excD  in  5  D-stage exception code; 0 = none
- bdD  in  1  D-stage instruction is in a branch delay slot
- pcD  in  32  D-stage PC
- ra1E, ra2E, waE  out  5  E-stage register numbers
- resE  out  3  E-stage result class
- tnewE  out  2  E-stage remaining cycles to result
- tnewM  out  2  value handed to the M stage: tnewE-1, saturating at 0
- excE  out  5  E-stage exception code
- bdE  out  1  E-stage delay-slot flag
- pcE  out  32  E-stage PC
- validE  out  1  E stage holds a real (non-bubble) instruction

Function
REQ-003 All E outputs SHALL be registered, except tnewM, which SHALL be combinational from tnewE.
REQ-004 On each rising clk edge with rst high, the update SHALL follow this priority: DEclr > !en > load.
REQ-005 DEclr=1 SHALL load a bubble on that edge, regardless of en:
- ra1E, ra2E, waE, resE, tnewE, excE, bdE = 0
- validE = 0
- pcE = pcD, so exception PC reporting stays meaningful.
REQ-006 DEclr=0, en=0 SHALL hold every register except tnewE.
REQ-007 During a hold, tnewE SHALL decrement by 1 per cycle, saturating at 0.
REQ-008 DEclr=0, en=1 SHALL load every E register from its D counterpart, with validE=1.
REQ-009 On load, if excD != 0, then waE=0 and resE=0, so an excepting instruction never writes back; ra1E, ra2E, excE, bdE and pcE still load.
REQ-010 On load, if resD=0 or waD=0, then waE=0 and resE=0, so register 0 is never a forwarding target.
REQ-011 tnewM SHALL equal (tnewE==0) ? 0 : tnewE-1.
REQ-012 Load latency SHALL be one cycle: D inputs sampled at edge N appear on E outputs after edge N.
REQ-013 If DEclr and en=0 occur together, DEclr SHALL win: a bubble loads.
REQ-014 tnewE arithmetic SHALL be 2-bit unsigned and SHALL never wrap below 0.

Reset
REQ-015 When rst is low, all registered outputs SHALL go to 0 immediately without waiting for a clock edge, including pcE=0 and validE=0; tnewM then reads 0.
REQ-016 The first edge after rst deasserts SHALL obey REQ-004, with no extra recovery cycle.
REQ-017 rst asserted in the middle of a hold SHALL discard the held instruction, and the stage SHALL stay empty until the next load.

Verification
REQ-018 Load: ra1D=3, ra2D=4, waD=5, resD=2, tnewD=2, pcD=0x3000, en=1 -> after one edge: ra1E=3, ra2E=4, waE=5, resE=2, tnewE=2, tnewM=1, validE=1, pcE=0x3000.
REQ-019 Hold countdown: after REQ-018, en=0 for 3 edges -> tnewE 1, 0, 0 and tnewM 0, 0, 0; all other outputs unchanged.
REQ-020 Bubble priority: DEclr=1, en=0, pcD=0x3004 -> after edge: waE=0, resE=0, tnewE=0, validE=0, pcE=0x3004.
REQ-021 Exception squash: excD=10, waD=8, resD=1, bdD=1, en=1 -> excE=10, bdE=1, waE=0, resE=0, validE=1.
REQ-022 Register-0 suppression: waD=0, resD=3 -> waE=0, resE=0; a separate case with resD=0, waD=7 -> waE=0.
REQ-023 Async reset: rst driven low mid-cycle between edges while stage loaded -> all outputs 0 before the next clk edge; rst high with en=1 -> normal load on the next edge.
